bram_image_loader: RTL and testbench

Upstream Avalon-MM master that fills and checks the 1024×32 on-chip program BRAM (`bram_onchip_memory2_1`, port s1) from a 32-bit valid/ready word stream supplied by the host MMIO path. It keeps the soft core in reset while it owns the BRAM. In LOAD mode it writes a contiguous, wrapping address range. In VERIFY mode it reads the same range back and compares it against the stream. In both modes it accumulates a 32-bit additive checksum.

---
 rtl/bram_image_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_bram_image_loader.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_image_loader.sv
// bram_image_loader
//   Avalon-MM master that fills (LOAD) or checks (VERIFY) the on-chip program
//   BRAM from a valid/ready word stream, holding the soft core in reset while
//   it owns the memory. Both modes keep a running additive checksum.
//
// Ports
//   clk, reset_n              : clock, async active-low reset
//   start, mode, base_addr,
//   word_count, abort         : job control (mode 0 = LOAD, 1 = VERIFY)
//   busy, done, error,
//   mismatch_addr, checksum   : job status
//   cpu_reset_req             : holds the core in reset while busy
//   in_valid/in_ready/in_data : word stream
//   bram_*                    : BRAM s1 master port (read latency 1)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | accepting stream words, each written one cycle after accept
// LFIN     | last registered write on the bus, then done
// V_READ   | read issued at addr
// V_WAIT   | read data returns, captured into rd_q
// V_CMP    | accepting one stream word and comparing against rd_q
module bram_image_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   mismatch_addr,
  output logic [DATA_W-1:0]   checksum,
  output logic                cpu_reset_req,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic [ADDR_W-1:0]   bram_address,
  output logic                bram_chipselect,
  output logic                bram_clken,
  output logic                bram_write,
  output logic [DATA_W-1:0]   bram_writedata,
  output logic [DATA_W/8-1:0] bram_byteenable,
  input  logic [DATA_W-1:0]   bram_readdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LFIN   = 3'd2,
    S_V_READ = 3'd3,
    S_V_WAIT = 3'd4,
    S_V_CMP  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   mismatch_addr_q, mismatch_addr_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   bram_address_q, bram_address_d;
  logic                bram_chipselect_q, bram_chipselect_d;
  logic                bram_write_q, bram_write_d;
  logic [DATA_W-1:0]   bram_writedata_q, bram_writedata_d;

  logic hs;
  logic last_word;

  // in_ready depends on the state register only, never on in_valid
  assign in_ready  = (state_q == S_LOAD) || (state_q == S_V_CMP);
  assign hs        = in_valid && in_ready;
  assign last_word = (remaining_q == CNT_ONE);

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    remaining_d       = remaining_q;
    checksum_d        = checksum_q;
    error_d           = error_q;
    mismatch_addr_d   = mismatch_addr_q;
    rd_d              = rd_q;
    done_d            = 1'b0;
    bram_address_d    = bram_address_q;
    bram_chipselect_d = 1'b0;
    bram_write_d      = 1'b0;
    bram_writedata_d  = bram_writedata_q;

    if (abort) begin
      // abort wins: no done, any pending write is dropped, status kept
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d          = base_addr;
            remaining_d     = word_count;
            checksum_d      = '0;
            error_d         = 1'b0;
            mismatch_addr_d = '0;
            if (word_count == '0) begin
              done_d = 1'b1;
            end else if (mode) begin
              state_d = S_V_READ;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (hs) begin
            bram_chipselect_d = 1'b1;
            bram_write_d      = 1'b1;
            bram_address_d    = addr_q;
            bram_writedata_d  = in_data;
            checksum_d        = checksum_q + in_data;
            addr_d            = addr_q + ADDR_ONE;
            remaining_d       = remaining_q - CNT_ONE;
            if (last_word) state_d = S_LFIN;
          end
        end
        S_LFIN: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_V_READ: begin
          state_d = S_V_WAIT;
        end
        S_V_WAIT: begin
          rd_d    = bram_readdata;
          state_d = S_V_CMP;
        end
        S_V_CMP: begin
          if (hs) begin
            checksum_d = checksum_q + in_data;
            if ((in_data != rd_q) && !error_q) begin
              error_d         = 1'b1;
              mismatch_addr_d = addr_q;
            end
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - CNT_ONE;
            if (last_word) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_V_READ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The read command is registered, so it is set up on the way into V_READ
    if (state_d == S_V_READ) begin
      bram_chipselect_d = 1'b1;
      bram_write_d      = 1'b0;
      bram_address_d    = addr_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      remaining_q       <= '0;
      checksum_q        <= '0;
      error_q           <= 1'b0;
      mismatch_addr_q   <= '0;
      rd_q              <= '0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
      bram_address_q    <= '0;
      bram_chipselect_q <= 1'b0;
      bram_write_q      <= 1'b0;
      bram_writedata_q  <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      remaining_q       <= remaining_d;
      checksum_q        <= checksum_d;
      error_q           <= error_d;
      mismatch_addr_q   <= mismatch_addr_d;
      rd_q              <= rd_d;
      done_q            <= done_d;
      busy_q            <= busy_d;
      bram_address_q    <= bram_address_d;
      bram_chipselect_q <= bram_chipselect_d;
      bram_write_q      <= bram_write_d;
      bram_writedata_q  <= bram_writedata_d;
    end
  end

  assign busy            = busy_q;
  assign cpu_reset_req   = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign mismatch_addr   = mismatch_addr_q;
  assign checksum        = checksum_q;
  assign bram_address    = bram_address_q;
  assign bram_chipselect = bram_chipselect_q;
  assign bram_clken      = bram_chipselect_q;
  assign bram_write      = bram_write_q;
  assign bram_writedata  = bram_writedata_q;
  assign bram_byteenable = '1;

endmodule

// File: tb/tb_bram_image_loader.sv
// Directed testbench for bram_image_loader with a 1-cycle-latency BRAM model
// and a write log used to check addresses, data and write timing.
module tb_bram_image_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic          busy, done, error, cpu_reset_req;
  logic [AW-1:0] mismatch_addr;
  logic [DW-1:0] checksum;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] bram_address;
  logic          bram_chipselect, bram_clken, bram_write;
  logic [DW-1:0] bram_writedata;
  logic [DW/8-1:0] bram_byteenable;
  logic [DW-1:0] bram_readdata = '0;

  bram_image_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .word_count(word_count), .abort(abort),
    .busy(busy), .done(done), .error(error), .mismatch_addr(mismatch_addr),
    .checksum(checksum), .cpu_reset_req(cpu_reset_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bram_address(bram_address), .bram_chipselect(bram_chipselect),
    .bram_clken(bram_clken), .bram_write(bram_write),
    .bram_writedata(bram_writedata), .bram_byteenable(bram_byteenable),
    .bram_readdata(bram_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int wr_addr_q[$];
  int wr_cyc_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_chipselect && bram_clken) begin
      if (bram_write) mem[bram_address] <= bram_writedata;
      else            bram_readdata <= mem[bram_address];
    end
  end

  always @(posedge clk) begin
    if (bram_chipselect) begin
      cs_cnt = cs_cnt + 1;
      if (bram_write) begin
        wr_addr_q.push_back(int'(bram_address));
        wr_data_q.push_back(bram_writedata);
        wr_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a back-to-back LOAD job and leaves the bench in the done cycle.
  task automatic load_words(input int b, input int n, input logic [DW-1:0] d0);
    start = 1'b1; mode = 1'b0; base_addr = AW'(b); word_count = (AW+1)'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = d0 + DW'(i);
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({busy, done, error, in_ready, cpu_reset_req, bram_chipselect, bram_clken, bram_write} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {busy, done, error, in_ready, cpu_reset_req, bram_chipselect, bram_clken, bram_write});
    end
    checks++;
    if (bram_address !== '0 || bram_writedata !== '0) begin
      errors++; $display("FAIL reset_bus got addr %0d wdata %0h want 0 0", bram_address, bram_writedata);
    end
    checks++;
    if (mismatch_addr !== '0 || checksum !== '0) begin
      errors++; $display("FAIL reset_status got mm %0d sum %0h want 0 0", mismatch_addr, checksum);
    end
    checks++;
    if (bram_byteenable !== 4'hF) begin
      errors++; $display("FAIL reset_be got %h want f", bram_byteenable);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_load_b2b();
    int n0 = wr_addr_q.size();
    logic rr_ok = 1'b1;
    start = 1'b1; mode = 1'b0; base_addr = AW'(0); word_count = (AW+1)'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 1);
      if (!(cpu_reset_req && busy && in_ready)) rr_ok = 1'b0;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || cpu_reset_req !== 1'b1) begin
      errors++; $display("FAIL b2b_lfin got done %b busy %b rr %b want 0 1 1", done, busy, cpu_reset_req);
    end
    step();
    checks++;
    if (!rr_ok) begin
      errors++; $display("FAIL b2b_cpu_reset got dropped want held");
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_reset_req !== 1'b0) begin
      errors++; $display("FAIL b2b_done got done %b busy %b rr %b want 1 0 0", done, busy, cpu_reset_req);
    end
    checks++;
    if (checksum !== 32'd10) begin
      errors++; $display("FAIL b2b_sum got %0d want 10", checksum);
    end
    checks++;
    if (wr_addr_q.size() !== n0 + 4) begin
      errors++; $display("FAIL b2b_nwr got %0d want %0d", wr_addr_q.size() - n0, 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[n0+i] !== i || wr_data_q[n0+i] !== DW'(i + 1) || wr_cyc_q[n0+i] !== wr_cyc_q[n0] + i) begin
          errors++;
          $display("FAIL b2b_wr%0d got a %0d d %0h dc %0d want a %0d d %0d dc %0d", i, wr_addr_q[n0+i],
                   wr_data_q[n0+i], wr_cyc_q[n0+i] - wr_cyc_q[n0], i, i + 1, i);
        end
      end
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL b2b_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_load_stall();
    int n0 = wr_addr_q.size();
    int beats = 0;
    int exp_a[4] = '{1022, 1023, 0, 1};
    start = 1'b1; mode = 1'b0; base_addr = AW'(1022); word_count = (AW+1)'(4);
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k % 2 == 0);
      in_data = 32'h100 + DW'(beats);
      if (in_valid && in_ready) beats++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (beats !== 4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_done got beats %0d done %b busy %b want 4 1 0", beats, done, busy);
    end
    checks++;
    if (checksum !== 32'h406) begin
      errors++; $display("FAIL stall_sum got %0h want 406", checksum);
    end
    checks++;
    if (wr_addr_q.size() !== n0 + 4) begin
      errors++; $display("FAIL stall_nwr got %0d want 4", wr_addr_q.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[n0+i] !== exp_a[i] || wr_data_q[n0+i] !== 32'h100 + DW'(i) ||
            wr_cyc_q[n0+i] !== wr_cyc_q[n0] + 2*i) begin
          errors++;
          $display("FAIL stall_wr%0d got a %0d d %0h dc %0d want a %0d d %0h dc %0d", i, wr_addr_q[n0+i],
                   wr_data_q[n0+i], wr_cyc_q[n0+i] - wr_cyc_q[n0], exp_a[i], 32'h100 + i, 2*i);
        end
      end
    end
    step();
  endtask

  task automatic test_verify();
    logic [DW-1:0] stream[6];
    logic [DW-1:0] exp_sum = '0;
    int n0;
    int prev = 0;
    int hs_cyc;
    logic got;
    load_words(3, 6, 32'hA5A5_0003);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL verify_preload got done %b want 1", done);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      stream[i] = 32'hA5A5_0003 + DW'(i);
    end
    stream[2] = stream[2] ^ 32'h0000_00FF;
    stream[4] = stream[4] ^ 32'h0000_0001;
    for (int i = 0; i < 6; i++) exp_sum = exp_sum + stream[i];
    n0 = wr_addr_q.size();
    start = 1'b1; mode = 1'b1; base_addr = AW'(3); word_count = (AW+1)'(6);
    step();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_data = stream[j];
      got = 1'b0; hs_cyc = 0;
      for (int t = 0; t < 10; t++) begin
        if (in_ready) begin
          got = 1'b1; hs_cyc = cyc;
          step();
          break;
        end
        step();
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL verify_hs%0d got timeout want handshake", j);
      end else if (j > 0 && hs_cyc - prev !== 3) begin
        errors++; $display("FAIL verify_rate%0d got %0d want 3", j, hs_cyc - prev);
      end
      prev = hs_cyc;
      if (j == 1) begin
        checks++;
        if (error !== 1'b0) begin
          errors++; $display("FAIL verify_early_err got %b want 0", error);
        end
      end
      if (j == 2) begin
        checks++;
        if (error !== 1'b1 || mismatch_addr !== AW'(5)) begin
          errors++; $display("FAIL verify_first_mm got err %b addr %0d want 1 5", error, mismatch_addr);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL verify_done got done %b busy %b want 1 0", done, busy);
    end
    checks++;
    if (error !== 1'b1 || mismatch_addr !== AW'(5)) begin
      errors++; $display("FAIL verify_err got err %b addr %0d want 1 5", error, mismatch_addr);
    end
    checks++;
    if (checksum !== exp_sum) begin
      errors++; $display("FAIL verify_sum got %0h want %0h", checksum, exp_sum);
    end
    checks++;
    if (wr_addr_q.size() !== n0) begin
      errors++; $display("FAIL verify_nowrite got %0d want 0", wr_addr_q.size() - n0);
    end
    step();
  endtask

  task automatic test_zero_count();
    int cs0 = cs_cnt;
    start = 1'b1; mode = 1'b0; base_addr = AW'(7); word_count = '0;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_reset_req !== 1'b0) begin
      errors++; $display("FAIL zero_done got done %b busy %b rr %b want 1 0 0", done, busy, cpu_reset_req);
    end
    checks++;
    if (checksum !== '0 || error !== 1'b0 || mismatch_addr !== '0) begin
      errors++; $display("FAIL zero_clear got sum %0h err %b mm %0d want 0 0 0", checksum, error, mismatch_addr);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cs_cnt !== cs0) begin
      errors++; $display("FAIL zero_after got done %b busy %b cs %0d want 0 0 0", done, busy, cs_cnt - cs0);
    end
  endtask

  task automatic test_abort();
    int n0 = wr_addr_q.size();
    logic saw_done = 1'b0;
    start = 1'b1; mode = 1'b0; base_addr = AW'(100); word_count = (AW+1)'(8);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_reset_req !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy %b done %b rr %b want 0 0 0", busy, done, cpu_reset_req);
    end
    checks++;
    if (checksum !== 32'h33) begin
      errors++; $display("FAIL abort_sum got %0h want 33", checksum);
    end
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done || wr_addr_q.size() !== n0 + 2) begin
      errors++; $display("FAIL abort_quiet got done %b nwr %0d want 0 2", saw_done, wr_addr_q.size() - n0);
    end else begin
      checks++;
      if (wr_addr_q[n0] !== 100 || wr_addr_q[n0+1] !== 101) begin
        errors++; $display("FAIL abort_addrs got %0d %0d want 100 101", wr_addr_q[n0], wr_addr_q[n0+1]);
      end
    end
    n0 = wr_addr_q.size();
    load_words(200, 2, 32'd7);
    checks++;
    if (done !== 1'b1 || checksum !== 32'd15) begin
      errors++; $display("FAIL abort_restart got done %b sum %0d want 1 15", done, checksum);
    end
    checks++;
    if (wr_addr_q.size() !== n0 + 2) begin
      errors++; $display("FAIL abort_restart_nwr got %0d want 2", wr_addr_q.size() - n0);
    end else if (wr_addr_q[n0] !== 200 || wr_addr_q[n0+1] !== 201) begin
      errors++; $display("FAIL abort_restart_addrs got %0d %0d want 200 201", wr_addr_q[n0], wr_addr_q[n0+1]);
    end
    step();
  endtask

  task automatic test_reset_mid_verify();
    int cs0;
    logic got;
    logic [DW-1:0] exp_sum;
    start = 1'b1; mode = 1'b1; base_addr = AW'(3); word_count = (AW+1)'(6);
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (in_ready) begin got = 1'b1; step(); break; end
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (!got || error !== 1'b1 || mismatch_addr !== AW'(3) || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre got hs %b err %b mm %0d busy %b want 1 1 3 1", got, error, mismatch_addr, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, in_ready, cpu_reset_req, bram_chipselect, bram_clken, bram_write} !== 8'b0) begin
      errors++;
      $display("FAIL rst_async_ctrl got %b want 00000000",
               {busy, done, error, in_ready, cpu_reset_req, bram_chipselect, bram_clken, bram_write});
    end
    checks++;
    if (checksum !== '0 || mismatch_addr !== '0 || bram_address !== '0 || bram_writedata !== '0) begin
      errors++; $display("FAIL rst_async_data got sum %0h mm %0d a %0d wd %0h want 0 0 0 0",
                         checksum, mismatch_addr, bram_address, bram_writedata);
    end
    cs0 = cs_cnt;
    step();
    step();
    checks++;
    if (cs_cnt !== cs0) begin
      errors++; $display("FAIL rst_no_access got %0d want 0", cs_cnt - cs0);
    end
    reset_n = 1'b1;
    step();
    exp_sum = 32'hA5A5_0003 + 32'hA5A5_0004;
    start = 1'b1; mode = 1'b1; base_addr = AW'(3); word_count = (AW+1)'(2);
    step();
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_data = 32'hA5A5_0003 + DW'(j);
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (in_ready) begin got = 1'b1; step(); break; end
        step();
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL rst_restart_hs%0d got timeout want handshake", j);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || checksum !== exp_sum) begin
      errors++; $display("FAIL rst_restart got done %b err %b sum %0h want 1 0 %0h", done, error, checksum, exp_sum);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_stall();
    test_verify();
    test_zero_count();
    test_abort();
    test_reset_mid_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
